osc_cmd_decoder: RTL

- Synchronous, parametrised byte-stream command decoder that loads per-oscillator control words (wave, freq, phase, amp) for NUM_OSC oscillators.
- Sits between the host byte link (UART/SPI receiver) and the oscillator bank.
- Adds over the previous generation: valid/ready handshake, atomic commit with per-osc update strobes, broadcast addressing, error reporting and an inter-byte timeout.

---
 rtl/osc_cmd_decoder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/osc_cmd_decoder.sv
// rtl/osc_cmd_decoder.sv - byte-stream command decoder loading per-oscillator wave/freq/phase/amp words
module osc_cmd_decoder #(
  parameter int NUM_OSC        = 2,
  parameter int WAVE_W         = 8,
  parameter int FREQ_W         = 24,
  parameter int PHASE_W        = 16,
  parameter int AMP_W          = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [7:0]                   i_data,
  input  logic                         i_data_valid,
  output logic                         o_ready,
  output logic [NUM_OSC*WAVE_W-1:0]    o_wave,
  output logic [NUM_OSC*FREQ_W-1:0]    o_freq,
  output logic [NUM_OSC*PHASE_W-1:0]   o_phase,
  output logic [NUM_OSC*AMP_W-1:0]     o_amp,
  output logic [NUM_OSC-1:0]           o_upd,
  output logic                         o_err,
  output logic [1:0]                   o_err_code
);

  // Payload byte counts per field (ceil(W/8))
  localparam int WAVE_B  = (WAVE_W  + 7) / 8;
  localparam int FREQ_B  = (FREQ_W  + 7) / 8;
  localparam int PHASE_B = (PHASE_W + 7) / 8;
  localparam int AMP_B   = (AMP_W   + 7) / 8;
  localparam int MAX_WF  = (WAVE_B  > FREQ_B) ? WAVE_B  : FREQ_B;
  localparam int MAX_PA  = (PHASE_B > AMP_B)  ? PHASE_B : AMP_B;
  localparam int MAX_B   = (MAX_WF  > MAX_PA) ? MAX_WF  : MAX_PA;
  localparam int BUF_W   = 8 * MAX_B;

  // Idle counter only needs to hold TIMEOUT_CYCLES-1; the expiring cycle is detected, not stored
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [4:0] NUM_OSC_L = 5'(NUM_OSC);
  localparam logic [3:0] IDX_BCAST = 4'hF;

  localparam logic [3:0] F_WAVE  = 4'd1;
  localparam logic [3:0] F_FREQ  = 4'd2;
  localparam logic [3:0] F_PHASE = 4'd3;
  localparam logic [3:0] F_AMP   = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        tgt;
  logic [3:0]        fld;
  logic [3:0]        bcnt;
  logic [BUF_W-1:0]  pbuf;
  logic [TO_W-1:0]   tcnt;

  logic              accept;
  logic [3:0]        cmd_idx;
  logic [3:0]        cmd_fld;
  logic              idx_ok;
  logic              fld_ok;
  logic [3:0]        fld_bytes;

  assign accept  = i_data_valid && o_ready;
  assign cmd_idx = i_data[7:4];
  assign cmd_fld = i_data[3:0];
  assign idx_ok  = (cmd_idx == IDX_BCAST) || ({1'b0, cmd_idx} < NUM_OSC_L);
  assign fld_ok  = (cmd_fld >= F_WAVE) && (cmd_fld <= F_AMP);

  // Number of payload bytes that follow a command for the requested field
  always_comb begin
    fld_bytes = 4'd0;
    case (cmd_fld)
      F_WAVE:  fld_bytes = 4'(WAVE_B);
      F_FREQ:  fld_bytes = 4'(FREQ_B);
      F_PHASE: fld_bytes = 4'(PHASE_B);
      F_AMP:   fld_bytes = 4'(AMP_B);
      default: fld_bytes = 4'd0;
    endcase
  end

  // Decoder FSM: parse command, collect payload with timeout, then commit atomically
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      o_ready    <= 1'b1;
      o_wave     <= '0;
      o_freq     <= '0;
      o_phase    <= '0;
      o_amp      <= '0;
      o_upd      <= '0;
      o_err      <= 1'b0;
      o_err_code <= 2'd0;
      tgt        <= 4'd0;
      fld        <= 4'd0;
      bcnt       <= 4'd0;
      pbuf       <= '0;
      tcnt       <= '0;
    end else begin
      o_upd <= '0;
      o_err <= 1'b0;
      case (state)
        S_IDLE: begin
          // 0x00 is a NOP: consumed without action
          if (accept && (i_data != 8'h00)) begin
            if (!idx_ok) begin
              o_err      <= 1'b1;
              o_err_code <= 2'd1;
            end else if (!fld_ok) begin
              o_err      <= 1'b1;
              o_err_code <= 2'd2;
            end else begin
              state <= S_PAYLOAD;
              tgt   <= cmd_idx;
              fld   <= cmd_fld;
              bcnt  <= fld_bytes;
              pbuf  <= '0;
              tcnt  <= '0;
            end
          end
        end

        S_PAYLOAD: begin
          // An accepted byte always wins over an expiring timeout
          if (accept) begin
            pbuf <= (pbuf << 8) | BUF_W'(i_data);
            tcnt <= '0;
            if (bcnt == 4'd1) begin
              state   <= S_COMMIT;
              o_ready <= 1'b0;
            end else begin
              bcnt <= bcnt - 4'd1;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            if (tcnt == TO_LAST) begin
              o_err      <= 1'b1;
              o_err_code <= 2'd3;
              state      <= S_IDLE;
              pbuf       <= '0;
              tcnt       <= '0;
            end else begin
              tcnt <= tcnt + TO_W'(1);
            end
          end
        end

        S_COMMIT: begin
          // Whole field is written in one edge so no partial value is ever visible
          for (int k = 0; k < NUM_OSC; k++) begin
            if ((tgt == IDX_BCAST) || (tgt == 4'(k))) begin
              o_upd[k] <= 1'b1;
              case (fld)
                F_WAVE:  o_wave[k*WAVE_W +: WAVE_W]    <= pbuf[WAVE_W-1:0];
                F_FREQ:  o_freq[k*FREQ_W +: FREQ_W]    <= pbuf[FREQ_W-1:0];
                F_PHASE: o_phase[k*PHASE_W +: PHASE_W] <= pbuf[PHASE_W-1:0];
                F_AMP:   o_amp[k*AMP_W +: AMP_W]       <= pbuf[AMP_W-1:0];
                default: ;
              endcase
            end
          end
          state   <= S_IDLE;
          o_ready <= 1'b1;
        end

        default: begin
          state   <= S_IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
